// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared widths, wait-counter width and FSM state encoding
//   for the writeback port arbiter.
package wb_arb_pkg;
   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int CNT_W      = 3;
   typedef enum logic [1:0] {IDLE, HOLD, FORCE} state_t;
endpackage

// File: rtl/wb_hold_buffer.sv
// wb_hold_buffer: one-entry register holding a deferred MDU result.
//   clk, rst       : clock, synchronous active-high reset
//   load           : capture load_rd/load_data, mark entry valid
//   clear          : empty the entry (takes priority over load)
//   valid, rd, data: held entry
module wb_hold_buffer
   import wb_arb_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  clear,
   input  logic [REG_ADDR_W-1:0] load_rd,
   input  logic [XLEN-1:0]       load_data,
   output logic                  valid,
   output logic [REG_ADDR_W-1:0] rd,
   output logic [XLEN-1:0]       data
);
   always_ff @(posedge clk)
      if (rst || clear) begin
         valid <= 1'b0;
         rd    <= '0;
         data  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         rd    <= load_rd;
         data  <= load_data;
      end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: single register-file write port shared by the MEM/WB
//   writeback and a multi-cycle unit (MDU), with a one-entry hold buffer.
//   clk, rst                         : clock, synchronous active-high reset
//   MEMWB_WriteBack/_rd/_WbData      : pipeline writeback request
//   mdu_valid/mdu_rd/mdu_data        : MDU result, mdu_ready = accepted
//   rf_we/rf_rd/rf_wdata             : register-file write (zero latency)
//   wb_stall                         : pipeline writeback refused this cycle
//   pend_valid/pend_rd               : held MDU result, for hazard detection
//   Macro WB_ARB_STARVE_GUARD_EN     : enables the wait counter and FORCE
//                                      state; otherwise the buffer drains
//                                      only on pipeline-idle cycles.
module wb_port_arbiter
   import wb_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  MEMWB_WriteBack,
   input  logic [REG_ADDR_W-1:0] MEMWB_rd,
   input  logic [XLEN-1:0]       MEMWB_WbData,
   input  logic                  mdu_valid,
   input  logic [REG_ADDR_W-1:0] mdu_rd,
   input  logic [XLEN-1:0]       mdu_data,
   output logic                  mdu_ready,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_rd,
   output logic [XLEN-1:0]       rf_wdata,
   output logic                  wb_stall,
   output logic                  pend_valid,
   output logic [REG_ADDR_W-1:0] pend_rd
);
   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_limit
      $error("STARVE_LIMIT must be in 1..7");
   end
   state_t                  state, state_nxt;
   logic                    pipe_req, mdu_req;
   logic                    sel_pipe, sel_buf, sel_mdu, load;
   logic                    buf_valid;
   logic [REG_ADDR_W-1:0]   buf_rd;
   logic [XLEN-1:0]         buf_data;
   logic                    starve;
`ifdef WB_ARB_STARVE_GUARD_EN
   logic [CNT_W-1:0]        cnt, cnt_inc;
   assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
   assign starve  = cnt_inc >= CNT_W'(STARVE_LIMIT);
`else
   assign starve  = 1'b0;
`endif
   // rd=0 writes are architecturally void, so they never request the port
   always_comb begin
      pipe_req  = MEMWB_WriteBack && (MEMWB_rd != '0);
      mdu_req   = mdu_valid && (mdu_rd != '0);
      sel_buf   = (state == FORCE) || ((state == HOLD) && !pipe_req);
      sel_pipe  = pipe_req && (state != FORCE);
      sel_mdu   = (state == IDLE) && !pipe_req && mdu_req;
      load      = (state == IDLE) && pipe_req && mdu_req;
      rf_we     = !rst && (sel_buf || sel_pipe || sel_mdu);
      rf_rd     = rst      ? '0 :
                  sel_buf  ? buf_rd :
                  sel_pipe ? MEMWB_rd :
                  sel_mdu  ? mdu_rd : '0;
      rf_wdata  = rst      ? '0 :
                  sel_buf  ? buf_data :
                  sel_pipe ? MEMWB_WbData :
                  sel_mdu  ? mdu_data : '0;
      mdu_ready = !rst && (state == IDLE);
`ifdef WB_ARB_STARVE_GUARD_EN
      wb_stall  = !rst && (state == FORCE);
`else
      wb_stall  = 1'b0;
`endif
      state_nxt = (state == IDLE) ? (load ? HOLD : IDLE) :
                  (state == HOLD) ? (!pipe_req ? IDLE : starve ? FORCE : HOLD) :
                  IDLE;
   end
   // reset hides the held entry immediately; the buffer itself empties at the edge
   assign pend_valid = buf_valid && !rst;
   assign pend_rd    = rst ? '0 : buf_rd;
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
`ifdef WB_ARB_STARVE_GUARD_EN
         cnt   <= '0;
`endif
      end else begin
         state <= state_nxt;
`ifdef WB_ARB_STARVE_GUARD_EN
         cnt   <= sel_buf ? '0 : ((state == HOLD) && pipe_req) ? cnt_inc : cnt;
`endif
      end
   wb_hold_buffer u_buf (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .clear     (sel_buf),
      .load_rd   (mdu_rd),
      .load_data (mdu_data),
      .valid     (buf_valid),
      .rd        (buf_rd),
      .data      (buf_data)
   );
endmodule
